// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit procesor core.
module cpu_control_unit #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             z_flag,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic               z_q, z_d, ill_q, ill_d, retire;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPC_W-1:0]   opc;
  logic               dec_alu, op_alu;
  assign opc     = instr[15 -: OPC_W];
  assign dec_alu = opc >= OPC_W'(1) && opc <= OPC_W'(5);
  assign op_alu  = op_q >= OPC_W'(1) && op_q <= OPC_W'(5);
  assign cnt_d   = cnt_q + CNT_W'(retire);
  assign z_flag    = z_q;
  assign illegal   = ill_q;
  assign instr_cnt = cnt_q;
  assign halted    = state_q == HALT;
  // strobes are gated by rst_n so an asynchronous reset silences them before the next edge
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    z_d      = z_q;
    ill_d    = ill_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_op   = 3'b000;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          op_d = opc;
          if (opc == OPC_W'(0)) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else if (dec_alu || opc == OPC_W'(9) || opc == OPC_W'(10) || opc == OPC_W'(11)) begin
            state_d = EXEC;
          end else if (opc == OPC_W'(6)) begin
            state_d = WB;
          end else if (opc == OPC_W'(7) || opc == OPC_W'(8)) begin
            state_d = MEM;
          end else if (opc == OPC_W'(15)) begin
            retire  = 1'b1;
            state_d = HALT;
          end else begin
            ill_d   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
        EXEC: begin
          if (op_alu) begin
            alu_op  = 3'(op_q - OPC_W'(1));
            z_d     = alu_zero;
            state_d = WB;
          end else begin
            pc_load = op_q == OPC_W'(9) || (op_q == OPC_W'(10) && z_q) || (op_q == OPC_W'(11) && !z_q);
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = op_q == OPC_W'(8);
          retire   = mem_ready && mem_we;
          state_d  = !mem_ready ? MEM : mem_we ? FETCH : WB;
        end
        WB: begin
          reg_we  = 1'b1;
          wb_sel  = op_q == OPC_W'(7) ? 2'b01 : op_q == OPC_W'(6) ? 2'b10 : 2'b00;
          retire  = 1'b1;
          state_d = FETCH;
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
